// File: rtl/regfile_debug_port.sv
// Debug master for the CPU register file: dumps all registers to an
// outbound stream or loads all registers from an inbound stream.
module regfile_debug_port #(
    parameter int NREGS = 16,
    parameter int AW    = 4,
    parameter int DW    = 16
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          dump_start,
    input  logic          load_start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          rf_wen,
    output logic [AW-1:0] rf_wsel,
    output logic [DW-1:0] rf_wdat,
    output logic [AW-1:0] rf_rsel1,
    input  logic [DW-1:0] rf_rdat1,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data
);

    typedef enum logic [2:0] {
        IDLE,
        DUMP_READ,
        DUMP_SEND,
        LOAD,
        DONE
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    state_t        state, state_n;
    logic [AW-1:0] idx, idx_n;
    logic [DW-1:0] odat, odat_n;
    logic          at_last;

    assign at_last = (idx == LAST);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            idx   <= '0;
            odat  <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            odat  <= odat_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        odat_n  = odat;
        case (state)
            IDLE: begin
                if (dump_start) begin
                    state_n = DUMP_READ;
                    idx_n   = '0;
                end else if (load_start) begin
                    state_n = LOAD;
                    idx_n   = '0;
                end
            end
            DUMP_READ: begin
                odat_n  = rf_rdat1;
                state_n = DUMP_SEND;
            end
            DUMP_SEND: begin
                if (out_ready) begin
                    if (at_last) begin
                        state_n = DONE;
                    end else begin
                        idx_n   = idx + AW'(1);
                        state_n = DUMP_READ;
                    end
                end
            end
            LOAD: begin
                if (in_valid) begin
                    if (at_last) state_n = DONE;
                    else         idx_n   = idx + AW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
                idx_n   = '0;
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase
        // Cancel wins over every transition, including a pending handshake
        if (abort) begin
            state_n = IDLE;
            idx_n   = '0;
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign in_ready  = (state == LOAD);
    assign rf_wen    = in_ready & in_valid;
    assign rf_wsel   = in_ready ? idx : '0;
    assign rf_wdat   = in_ready ? in_data : '0;
    assign rf_rsel1  = (state == DUMP_READ || state == DUMP_SEND) ? idx : '0;
    assign out_valid = (state == DUMP_SEND);
    assign out_last  = out_valid & at_last;
    assign out_data  = odat;

endmodule

// File: tb/tb_regfile_debug_port.sv
// Bench for regfile_debug_port: register file model, vector table,
// scoreboarded dump/load sequences with random handshakes.
module tb_regfile_debug_port;

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        dump_start = 1'b0;
    logic        load_start = 1'b0;
    logic        abort = 1'b0;
    logic        busy, done, rf_wen;
    logic [3:0]  rf_wsel, rf_rsel1;
    logic [15:0] rf_wdat, rf_rdat1;
    logic        out_valid, out_last, in_ready;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0;

    int checks = 0;
    int failures = 0;

    logic [15:0] rf [16];
    logic [15:0] exp_rf [16];
    logic        preset = 1'b0;

    regfile_debug_port #(.NREGS(16), .AW(4), .DW(16)) dut (
        .CLK(CLK), .nRST(nRST),
        .dump_start(dump_start), .load_start(load_start), .abort(abort),
        .busy(busy), .done(done),
        .rf_wen(rf_wen), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
        .rf_rsel1(rf_rsel1), .rf_rdat1(rf_rdat1),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (preset) begin
            for (int i = 0; i < 16; i++) rf[i] <= 16'hA000 + 16'(i);
        end else if (rf_wen) begin
            rf[rf_wsel] <= rf_wdat;
        end
    end
    assign rf_rdat1 = rf[rf_rsel1];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_wen"}, 32'(rf_wen), 0);
        chk({tag, "_ovalid"}, 32'(out_valid), 0);
        chk({tag, "_olast"}, 32'(out_last), 0);
        chk({tag, "_iready"}, 32'(in_ready), 0);
        chk({tag, "_wsel"}, 32'(rf_wsel), 0);
        chk({tag, "_rsel"}, 32'(rf_rsel1), 0);
        chk({tag, "_wdat"}, 32'(rf_wdat), 0);
        chk({tag, "_odata"}, 32'(out_data), 0);
    endtask

    // mode 0: ready always high; 1: random ready; 2: 5-cycle stall on word 3
    task automatic do_dump(input int mode, input bit both);
        int n = 0;
        int cyc = 0;
        int last_t = -1;
        int stall = 0;
        int dones = 0;
        dump_start = 1'b1;
        load_start = both;
        out_ready = 1'b1;
        @(negedge CLK);
        dump_start = 1'b0;
        load_start = 1'b0;
        while (n < 16 && cyc < 400) begin
            chk("dump_busy", 32'(busy), 1);
            chk("dump_wen", 32'(rf_wen), 0);
            if (done) dones++;
            if (out_valid) begin
                if (mode == 2 && n == 3 && stall < 5) begin
                    out_ready = 1'b0;
                    stall++;
                    chk("stall_data", 32'(out_data), 32'(exp_rf[3]));
                end else begin
                    out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (out_ready) begin
                    chk("dump_data", 32'(out_data), 32'(exp_rf[n]));
                    chk("dump_last", 32'(out_last), 32'(n == 15));
                    chk("dump_rsel", 32'(rf_rsel1), 32'(n));
                    if (mode == 0 && n == 0)
                        chk("dump_first_cyc", 32'(cyc), 1);
                    if (mode == 0 && n > 0)
                        chk("dump_gap", 32'(cyc - last_t), 2);
                    last_t = cyc;
                    n++;
                end
            end else begin
                out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            @(negedge CLK);
            cyc++;
        end
        out_ready = 1'b0;
        chk("dump_words", 32'(n), 16);
        chk("dump_early_done", 32'(dones), 0);
        if (mode == 2) chk("dump_stall_cycles", 32'(stall), 5);
        chk("dump_done", 32'(done), 1);
        chk("dump_done_busy", 32'(busy), 1);
        @(negedge CLK);
        chk("dump_idle_busy", 32'(busy), 0);
        chk("dump_idle_done", 32'(done), 0);
    endtask

    // mode 0: 0x0100*i data, in_valid toggling; 1: random data and valid
    task automatic do_load(input int mode, input int abort_at);
        logic [15:0] d [16];
        int n = 0;
        int cyc = 0;
        bit aborted = 1'b0;
        for (int i = 0; i < 16; i++)
            d[i] = (mode == 0) ? 16'(16'h0100 * i) : 16'($urandom);
        load_start = 1'b1;
        @(negedge CLK);
        load_start = 1'b0;
        while (n < 16 && cyc < 400 && !aborted) begin
            if (abort_at == n) begin
                abort = 1'b1;
                in_valid = 1'b0;
                @(negedge CLK);
                abort = 1'b0;
                aborted = 1'b1;
                chk("abort_busy", 32'(busy), 0);
                chk("abort_iready", 32'(in_ready), 0);
                chk("abort_done", 32'(done), 0);
                @(negedge CLK);
                chk("abort_done2", 32'(done), 0);
            end else begin
                in_valid = (mode == 0) ? ((cyc % 2) == 1)
                                       : 1'($urandom_range(0, 1));
                in_data = d[n];
                #1;
                chk("load_iready", 32'(in_ready), 1);
                chk("load_wen", 32'(rf_wen), 32'(in_valid));
                chk("load_wsel", 32'(rf_wsel), 32'(n));
                chk("load_wdat", 32'(rf_wdat), 32'(d[n]));
                chk("load_done_early", 32'(done), 0);
                if (in_valid) begin
                    exp_rf[n] = d[n];
                    n++;
                end
                @(negedge CLK);
                cyc++;
            end
        end
        in_valid = 1'b0;
        if (!aborted) begin
            chk("load_words", 32'(n), 16);
            chk("load_done", 32'(done), 1);
            chk("load_done_wen", 32'(rf_wen), 0);
            @(negedge CLK);
            chk("load_idle_busy", 32'(busy), 0);
        end
        for (int i = 0; i < 16; i++)
            chk($sformatf("rf_%0d", i), 32'(rf[i]), 32'(exp_rf[i]));
    endtask

    typedef struct {
        logic ds, ls, ab, ordy;
        logic busy, done, ov, ir;
    } vec_t;

    vec_t vt [9];

    initial begin
        vt[0] = '{0, 0, 0, 0, 0, 0, 0, 0};
        vt[1] = '{1, 1, 0, 0, 1, 0, 0, 0};
        vt[2] = '{0, 0, 0, 0, 1, 0, 1, 0};
        vt[3] = '{0, 1, 0, 0, 1, 0, 1, 0};
        vt[4] = '{0, 0, 1, 1, 0, 0, 0, 0};
        vt[5] = '{0, 1, 0, 0, 1, 0, 0, 1};
        vt[6] = '{1, 0, 0, 0, 1, 0, 0, 1};
        vt[7] = '{0, 0, 1, 0, 0, 0, 0, 0};
        vt[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 16; i++) exp_rf[i] = 16'hA000 + 16'(i);

        #1 nRST = 1'b0;
        #1 chk_reset_outputs("reset");
        preset = 1'b1;
        @(negedge CLK);
        preset = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        chk_reset_outputs("idle");

        for (int i = 0; i < 9; i++) begin
            dump_start = vt[i].ds;
            load_start = vt[i].ls;
            abort = vt[i].ab;
            out_ready = vt[i].ordy;
            @(negedge CLK);
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].busy));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vt[i].done));
            chk($sformatf("vec%0d_ovalid", i), 32'(out_valid), 32'(vt[i].ov));
            chk($sformatf("vec%0d_iready", i), 32'(in_ready), 32'(vt[i].ir));
            chk($sformatf("vec%0d_wen", i), 32'(rf_wen), 0);
        end
        dump_start = 1'b0;
        load_start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b0;

        do_dump(0, 1'b0);
        do_load(0, -1);
        do_dump(0, 1'b0);
        do_dump(2, 1'b0);
        do_load(1, 6);
        do_dump(0, 1'b1);
        for (int r = 0; r < 3; r++) begin
            do_load(1, -1);
            do_dump(1, 1'b0);
        end

        dump_start = 1'b1;
        out_ready = 1'b1;
        @(negedge CLK);
        dump_start = 1'b0;
        repeat (6) @(negedge CLK);
        #2 nRST = 1'b0;
        #1 chk_reset_outputs("midreset");
        @(negedge CLK);
        nRST = 1'b1;
        out_ready = 1'b0;
        @(negedge CLK);
        chk("post_reset_busy", 32'(busy), 0);
        do_dump(0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
